// File: rtl/id_stage.sv
// RV32I instruction-decode stage: register file with write-through bypass,
// control decode, immediate generation, branch target and load-use hazard logic.
module id_stage #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] if_id_pc,
   input  logic [31:0]     if_id_instr,
   input  logic            if_id_valid,
   input  logic            ex_redirect,
   input  logic            id_ex_mem_read,
   input  logic [4:0]      id_ex_rd,
   input  logic            wb_reg_write,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_pc_p4,
   output logic [XLEN-1:0] id_branch_target,
   output logic [6:0]      id_funct7,
   output logic [2:0]      id_funct3,
   output logic [4:0]      id_rs1,
   output logic [4:0]      id_rs2,
   output logic [4:0]      id_rd,
   output logic [XLEN-1:0] id_rd1,
   output logic [XLEN-1:0] id_rd2,
   output logic            id_branch,
   output logic            id_jump,
   output logic            id_jump_src,
   output logic [1:0]      id_alu_op,
   output logic            id_alu_src_a,
   output logic [1:0]      id_alu_src_b,
   output logic            id_mem_write,
   output logic            id_mem_read,
   output logic            id_reg_write,
   output logic [1:0]      id_reg_write_src,
   output logic [XLEN-1:0] id_imm,
   output logic            pc_stall,
   output logic            if_id_stall,
   output logic            id_ex_flush,
   output logic            illegal_instr
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   logic [6:0]      opcode;
   logic [4:0]      rs1, rs2, rd;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign opcode = if_id_instr[6:0];
   assign rd     = if_id_instr[11:7];
   assign rs1    = if_id_instr[19:15];
   assign rs2    = if_id_instr[24:20];

   assign imm_i = {{(XLEN-12){if_id_instr[31]}}, if_id_instr[31:20]};
   assign imm_s = {{(XLEN-12){if_id_instr[31]}}, if_id_instr[31:25], if_id_instr[11:7]};
   assign imm_b = {{(XLEN-12){if_id_instr[31]}}, if_id_instr[7], if_id_instr[30:25],
                   if_id_instr[11:8], 1'b0};
   assign imm_u = {if_id_instr[31:12], 12'b0};
   assign imm_j = {{(XLEN-20){if_id_instr[31]}}, if_id_instr[19:12], if_id_instr[20],
                   if_id_instr[30:21], 1'b0};

   // Register file; entry 0 is never written and reads of x0 are forced to zero.
   logic [XLEN-1:0] regs [NREGS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wb_reg_write && wb_rd != 5'd0) begin
         regs[wb_rd] <= wb_data;
      end
   end

   logic [XLEN-1:0] rf_rs1, rf_rs2;

   assign rf_rs1 = (rs1 == 5'd0) ? '0 :
                   (wb_reg_write && wb_rd == rs1) ? wb_data : regs[rs1];
   assign rf_rs2 = (rs2 == 5'd0) ? '0 :
                   (wb_reg_write && wb_rd == rs2) ? wb_data : regs[rs2];

   // Raw decode, independent of if_id_valid; gated below.
   logic            known, rs1_used, rs2_used;
   logic            c_branch, c_jump, c_jump_src, c_src_a;
   logic            c_mem_write, c_mem_read, c_reg_write;
   logic [1:0]      c_alu_op, c_src_b, c_wsrc;
   logic [XLEN-1:0] imm;

   always_comb begin
      known       = 1'b0;
      rs1_used    = 1'b1;
      rs2_used    = 1'b0;
      imm         = '0;
      c_branch    = 1'b0;
      c_jump      = 1'b0;
      c_jump_src  = 1'b0;
      c_src_a     = 1'b0;
      c_mem_write = 1'b0;
      c_mem_read  = 1'b0;
      c_reg_write = 1'b0;
      c_alu_op    = 2'b00;
      c_src_b     = 2'b00;
      c_wsrc      = 2'b00;
      case (opcode)
         OPC_LUI: begin
            known = 1'b1; rs1_used = 1'b0; imm = imm_u;
            c_src_b = 2'b01; c_reg_write = 1'b1;
         end
         OPC_AUIPC: begin
            known = 1'b1; rs1_used = 1'b0; imm = imm_u;
            c_src_a = 1'b1; c_src_b = 2'b01; c_reg_write = 1'b1;
         end
         OPC_JAL: begin
            known = 1'b1; rs1_used = 1'b0; imm = imm_j;
            c_jump = 1'b1; c_wsrc = 2'b10; c_reg_write = 1'b1;
         end
         OPC_JALR: begin
            known = 1'b1; imm = imm_i;
            c_jump = 1'b1; c_jump_src = 1'b1; c_wsrc = 2'b10; c_reg_write = 1'b1;
         end
         OPC_BRANCH: begin
            known = 1'b1; rs2_used = 1'b1; imm = imm_b;
            c_branch = 1'b1; c_alu_op = 2'b01;
         end
         OPC_LOAD: begin
            known = 1'b1; imm = imm_i;
            c_mem_read = 1'b1; c_src_b = 2'b01; c_wsrc = 2'b01; c_reg_write = 1'b1;
         end
         OPC_STORE: begin
            known = 1'b1; rs2_used = 1'b1; imm = imm_s;
            c_mem_write = 1'b1; c_src_b = 2'b01;
         end
         OPC_OPIMM: begin
            known = 1'b1; imm = imm_i;
            c_alu_op = 2'b11; c_src_b = 2'b01; c_reg_write = 1'b1;
         end
         OPC_OP: begin
            known = 1'b1; rs2_used = 1'b1;
            c_alu_op = 2'b10; c_reg_write = 1'b1;
         end
         default: ;
      endcase
   end

   logic ctl_en;
   assign ctl_en = if_id_valid && known;

   assign id_branch        = ctl_en && c_branch;
   assign id_jump          = ctl_en && c_jump;
   assign id_jump_src      = ctl_en && c_jump_src;
   assign id_alu_op        = ctl_en ? c_alu_op : 2'b00;
   assign id_alu_src_a     = ctl_en && c_src_a;
   assign id_alu_src_b     = ctl_en ? c_src_b : 2'b00;
   assign id_mem_write     = ctl_en && c_mem_write;
   assign id_mem_read      = ctl_en && c_mem_read;
   assign id_reg_write     = ctl_en && c_reg_write && (rd != 5'd0);
   assign id_reg_write_src = ctl_en ? c_wsrc : 2'b00;

   assign id_pc            = if_id_pc;
   assign id_pc_p4         = if_id_pc + XLEN'(4);
   assign id_branch_target = if_id_pc + imm;
   assign id_imm           = imm;
   assign id_funct7        = if_id_instr[31:25];
   assign id_funct3        = if_id_instr[14:12];
   assign id_rs1           = rs1;
   assign id_rs2           = rs2;
   assign id_rd            = rd;
   // LUI feeds rs1 into the adder as zero so that add(rd1, imm) yields the U immediate.
   assign id_rd1           = (opcode == OPC_LUI) ? '0 : rf_rs1;
   assign id_rd2           = rf_rs2;

   // A redirect squashes this instruction, so it must not hold the front end.
   logic load_use;
   assign load_use = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                     ((rs1_used && id_ex_rd == rs1) || (rs2_used && id_ex_rd == rs2));

   assign pc_stall    = load_use && !ex_redirect;
   assign if_id_stall = load_use && !ex_redirect;
   assign id_ex_flush = load_use || ex_redirect || !if_id_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         illegal_instr <= 1'b0;
      end else if (if_id_valid && !known && !ex_redirect) begin
         illegal_instr <= 1'b1;
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed vector table, hand-written register-file and
// sticky-flag sequences, then random instructions against a reference model.
module tb_id_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] if_id_pc, if_id_instr;
   logic        if_id_valid, ex_redirect, id_ex_mem_read;
   logic [4:0]  id_ex_rd;
   logic        wb_reg_write;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [31:0] id_pc, id_pc_p4, id_branch_target;
   logic [6:0]  id_funct7;
   logic [2:0]  id_funct3;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [31:0] id_rd1, id_rd2;
   logic        id_branch, id_jump, id_jump_src;
   logic [1:0]  id_alu_op;
   logic        id_alu_src_a;
   logic [1:0]  id_alu_src_b;
   logic        id_mem_write, id_mem_read, id_reg_write;
   logic [1:0]  id_reg_write_src;
   logic [31:0] id_imm;
   logic        pc_stall, if_id_stall, id_ex_flush, illegal_instr;

   id_stage dut (
      .clk(clk), .rst(rst),
      .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
      .ex_redirect(ex_redirect), .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
      .id_pc(id_pc), .id_pc_p4(id_pc_p4), .id_branch_target(id_branch_target),
      .id_funct7(id_funct7), .id_funct3(id_funct3),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_rd1(id_rd1), .id_rd2(id_rd2),
      .id_branch(id_branch), .id_jump(id_jump), .id_jump_src(id_jump_src),
      .id_alu_op(id_alu_op), .id_alu_src_a(id_alu_src_a), .id_alu_src_b(id_alu_src_b),
      .id_mem_write(id_mem_write), .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
      .id_reg_write_src(id_reg_write_src), .id_imm(id_imm),
      .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_flush(id_ex_flush),
      .illegal_instr(illegal_instr)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       branch;
      logic       jump;
      logic       jump_src;
      logic [1:0] alu_op;
      logic       src_a;
      logic [1:0] src_b;
      logic       mem_write;
      logic       mem_read;
      logic       reg_write;
      logic [1:0] wsrc;
   } ctrl_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        valid;
      logic        redir;
      logic        mr;
      logic [4:0]  exrd;
      ctrl_t       ctrl;
      logic        chk_imm;
      logic [31:0] imm;
      logic        chk_tgt;
      logic [31:0] target;
      logic        stall;
      logic        flush;
   } vec_t;

   int checks = 0;
   int errors = 0;

   logic [31:0] model_rf [32];
   logic        model_ill;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic valid,
                        input logic redir, input logic mr, input logic [4:0] exrd);
      if_id_instr    = instr;
      if_id_pc       = pc;
      if_id_valid    = valid;
      ex_redirect    = redir;
      id_ex_mem_read = mr;
      id_ex_rd       = exrd;
   endtask

   task automatic wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
      wb_reg_write = en;
      wb_rd        = rd;
      wb_data      = data;
   endtask

   function automatic ctrl_t dut_ctrl();
      return {id_branch, id_jump, id_jump_src, id_alu_op, id_alu_src_a, id_alu_src_b,
              id_mem_write, id_mem_read, id_reg_write, id_reg_write_src};
   endfunction

   // ---------------- reference model ----------------
   function automatic logic ref_known(input logic [6:0] op);
      return op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
   endfunction

   function automatic ctrl_t ref_ctrl(input logic [31:0] ins, input logic valid);
      ctrl_t c;
      c = '0;
      case (ins[6:0])
         7'h37: begin c.src_b = 2'd1; c.reg_write = 1'b1; end
         7'h17: begin c.src_a = 1'b1; c.src_b = 2'd1; c.reg_write = 1'b1; end
         7'h6F: begin c.jump = 1'b1; c.wsrc = 2'd2; c.reg_write = 1'b1; end
         7'h67: begin c.jump = 1'b1; c.jump_src = 1'b1; c.wsrc = 2'd2; c.reg_write = 1'b1; end
         7'h63: begin c.branch = 1'b1; c.alu_op = 2'd1; end
         7'h03: begin c.mem_read = 1'b1; c.src_b = 2'd1; c.wsrc = 2'd1; c.reg_write = 1'b1; end
         7'h23: begin c.mem_write = 1'b1; c.src_b = 2'd1; end
         7'h13: begin c.alu_op = 2'd3; c.src_b = 2'd1; c.reg_write = 1'b1; end
         7'h33: begin c.alu_op = 2'd2; c.reg_write = 1'b1; end
         default: ;
      endcase
      if (ins[11:7] == 5'd0) c.reg_write = 1'b0;
      if (!valid) c = '0;
      return c;
   endfunction

   function automatic logic [31:0] ref_imm(input logic [31:0] ins);
      int s;
      s = int'($signed(ins));
      case (ins[6:0])
         7'h13, 7'h03, 7'h67: return s >>> 20;
         7'h23: return ((s >>> 25) << 5) | int'(ins[11:7]);
         7'h63: return ((s >>> 31) << 12) | (int'(ins[7]) << 11) |
                       (int'(ins[30:25]) << 5) | (int'(ins[11:8]) << 1);
         7'h37, 7'h17: return ins & 32'hFFFF_F000;
         7'h6F: return ((s >>> 31) << 20) | (int'(ins[19:12]) << 12) |
                       (int'(ins[20]) << 11) | (int'(ins[30:21]) << 1);
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] ref_read(input logic [4:0] idx);
      if (idx == 5'd0) return 32'h0;
      if (wb_reg_write && wb_rd == idx) return wb_data;
      return model_rf[idx];
   endfunction

   function automatic logic ref_load_use(input logic [31:0] ins);
      logic [6:0] op;
      logic       u1, u2;
      op = ins[6:0];
      u1 = !(op inside {7'h37, 7'h17, 7'h6F});
      u2 = op inside {7'h63, 7'h23, 7'h33};
      return id_ex_mem_read && id_ex_rd != 5'd0 &&
             ((u1 && id_ex_rd == ins[19:15]) || (u2 && id_ex_rd == ins[24:20]));
   endfunction

   // ---------------- directed vector table ----------------
   vec_t vecs [17];

   task automatic fill_table();
      //          instr          pc            v  rd mr exrd  ctrl{br,j,js,op,sa,sb,mw,mr,rw,ws}                         ci imm           ct target        st fl
      vecs[0]  = '{32'hFE208CE3, 32'h0000_0100, 1, 0, 0, 5'd0,  '{1,0,0,2'd1,0,2'd0,0,0,0,2'd0}, 1, 32'hFFFF_FFF8, 1, 32'h0000_00F8, 0, 0};
      vecs[1]  = '{32'hFE208CE3, 32'h0000_0004, 1, 0, 0, 5'd0,  '{1,0,0,2'd1,0,2'd0,0,0,0,2'd0}, 1, 32'hFFFF_FFF8, 1, 32'hFFFF_FFFC, 0, 0};
      vecs[2]  = '{32'h000280E7, 32'h0000_0200, 1, 0, 0, 5'd0,  '{0,1,1,2'd0,0,2'd0,0,0,1,2'd2}, 1, 32'h0000_0000, 0, 32'h0,         0, 0};
      vecs[3]  = '{32'h001000EF, 32'h0000_1000, 1, 0, 0, 5'd0,  '{0,1,0,2'd0,0,2'd0,0,0,1,2'd2}, 1, 32'h0000_0800, 1, 32'h0000_1800, 0, 0};
      vecs[4]  = '{32'h0000006F, 32'hFFFF_FFFC, 1, 0, 0, 5'd0,  '{0,1,0,2'd0,0,2'd0,0,0,0,2'd2}, 1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 0, 0};
      vecs[5]  = '{32'h00218233, 32'h0000_0040, 1, 0, 1, 5'd3,  '{0,0,0,2'd2,0,2'd0,0,0,1,2'd0}, 0, 32'h0,         0, 32'h0,         1, 1};
      vecs[6]  = '{32'h00218233, 32'h0000_0040, 1, 0, 1, 5'd2,  '{0,0,0,2'd2,0,2'd0,0,0,1,2'd0}, 0, 32'h0,         0, 32'h0,         1, 1};
      vecs[7]  = '{32'h00218233, 32'h0000_0040, 1, 0, 0, 5'd3,  '{0,0,0,2'd2,0,2'd0,0,0,1,2'd0}, 0, 32'h0,         0, 32'h0,         0, 0};
      vecs[8]  = '{32'h00218233, 32'h0000_0040, 1, 1, 1, 5'd3,  '{0,0,0,2'd2,0,2'd0,0,0,1,2'd0}, 0, 32'h0,         0, 32'h0,         0, 1};
      vecs[9]  = '{32'h123451B7, 32'h0000_0080, 1, 0, 1, 5'd3,  '{0,0,0,2'd0,0,2'd1,0,0,1,2'd0}, 1, 32'h1234_5000, 0, 32'h0,         0, 0};
      vecs[10] = '{32'h123451B7, 32'h0000_0080, 1, 0, 1, 5'd8,  '{0,0,0,2'd0,0,2'd1,0,0,1,2'd0}, 1, 32'h1234_5000, 0, 32'h0,         0, 0};
      vecs[11] = '{32'hFFF40193, 32'h0000_0090, 1, 0, 1, 5'd8,  '{0,0,0,2'd3,0,2'd1,0,0,1,2'd0}, 1, 32'hFFFF_FFFF, 0, 32'h0,         1, 1};
      vecs[12] = '{32'h0021A623, 32'h0000_00A0, 1, 0, 1, 5'd2,  '{0,0,0,2'd0,0,2'd1,1,0,0,2'd0}, 1, 32'h0000_000C, 0, 32'h0,         1, 1};
      vecs[13] = '{32'hFFC32283, 32'h0000_00B0, 1, 0, 1, 5'd28, '{0,0,0,2'd0,0,2'd1,0,1,1,2'd1}, 1, 32'hFFFF_FFFC, 0, 32'h0,         0, 0};
      vecs[14] = '{32'h00001097, 32'h0000_00C0, 1, 0, 0, 5'd0,  '{0,0,0,2'd0,1,2'd1,0,0,1,2'd0}, 1, 32'h0000_1000, 0, 32'h0,         0, 0};
      vecs[15] = '{32'h00218233, 32'h0000_00D0, 0, 0, 0, 5'd3,  '{0,0,0,2'd0,0,2'd0,0,0,0,2'd0}, 0, 32'h0,         0, 32'h0,         0, 1};
      vecs[16] = '{32'h0000007F, 32'h0000_00E0, 1, 0, 0, 5'd0,  '{0,0,0,2'd0,0,2'd0,0,0,0,2'd0}, 0, 32'h0,         0, 32'h0,         0, 0};
   endtask

   // ---------------- main sequence ----------------
   logic [6:0]  ops [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

   initial begin
      rst = 1'b1;
      drive(32'h00028013, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0);
      wb(1'b0, 5'd0, 32'h0);
      step(); step();
      rst = 1'b0;
      @(negedge clk);
      check("reset_illegal", 32'(illegal_instr), 32'h0);
      check("reset_rd1_x5", id_rd1, 32'h0);

      // Write x5, then reset mid-run (with a simultaneous WB write to x6).
      step();
      wb(1'b1, 5'd5, 32'hDEAD_BEEF);
      step();
      wb(1'b0, 5'd0, 32'h0);
      @(negedge clk);
      check("x5_written", id_rd1, 32'hDEAD_BEEF);
      step();
      rst = 1'b1;
      wb(1'b1, 5'd6, 32'h1111_1111);
      step();
      rst = 1'b0;
      wb(1'b0, 5'd0, 32'h0);
      drive(32'h006280B3, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0);
      @(negedge clk);
      check("x5_after_reset", id_rd1, 32'h0);
      check("x6_reset_prio", id_rd2, 32'h0);

      // x0 writes are discarded, both in the bypass and in the array.
      step();
      wb(1'b1, 5'd0, 32'h0000_1234);
      drive(32'h00000013, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0);
      @(negedge clk);
      check("x0_bypass", id_rd1, 32'h0);
      step();
      wb(1'b0, 5'd0, 32'h0);
      @(negedge clk);
      check("x0_stored", id_rd1, 32'h0);

      // Write-through bypass on x7.
      step();
      wb(1'b1, 5'd7, 32'hA5A5_A5A5);
      drive(32'h007380B3, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0);
      @(negedge clk);
      check("bypass_rd1", id_rd1, 32'hA5A5_A5A5);
      check("bypass_rd2", id_rd2, 32'hA5A5_A5A5);
      step();
      wb(1'b1, 5'd7, 32'h5A5A_5A5A);
      @(negedge clk);
      check("bypass_newer", id_rd1, 32'h5A5A_5A5A);
      step();
      wb(1'b0, 5'd0, 32'h0);
      @(negedge clk);
      check("x7_stored", id_rd1, 32'h5A5A_5A5A);

      // Directed decode / hazard vectors.
      fill_table();
      for (int i = 0; i < 17; i++) begin
         step();
         drive(vecs[i].instr, vecs[i].pc, vecs[i].valid, vecs[i].redir, vecs[i].mr, vecs[i].exrd);
         @(negedge clk);
         check($sformatf("vec%0d_ctrl", i), 32'(dut_ctrl()), 32'(vecs[i].ctrl));
         check($sformatf("vec%0d_pc_p4", i), id_pc_p4, vecs[i].pc + 32'd4);
         check($sformatf("vec%0d_pc_stall", i), 32'(pc_stall), 32'(vecs[i].stall));
         check($sformatf("vec%0d_if_id_stall", i), 32'(if_id_stall), 32'(vecs[i].stall));
         check($sformatf("vec%0d_flush", i), 32'(id_ex_flush), 32'(vecs[i].flush));
         if (vecs[i].chk_imm) check($sformatf("vec%0d_imm", i), id_imm, vecs[i].imm);
         if (vecs[i].chk_tgt) check($sformatf("vec%0d_target", i), id_branch_target, vecs[i].target);
      end

      // Sticky illegal-opcode flag.
      step();
      rst = 1'b1;
      drive(32'h00000013, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0);
      step();
      rst = 1'b0;
      @(negedge clk);
      check("ill_cleared", 32'(illegal_instr), 32'h0);
      step();
      drive(32'h0000007F, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0);
      @(negedge clk);
      check("ill_ctrl_zero", 32'(dut_ctrl()), 32'h0);
      step();
      drive(32'h00000013, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check($sformatf("ill_hold%0d", i), 32'(illegal_instr), 32'h1);
         step();
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      check("ill_rst", 32'(illegal_instr), 32'h0);
      step();
      drive(32'h0000007F, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         @(negedge clk);
         check($sformatf("ill_invalid%0d", i), 32'(illegal_instr), 32'h0);
      end
      drive(32'h0000007F, 32'h0, 1'b1, 1'b1, 1'b0, 5'd0);
      for (int i = 0; i < 2; i++) begin
         step();
         @(negedge clk);
         check($sformatf("ill_redirect%0d", i), 32'(illegal_instr), 32'h0);
      end

      // Random instructions against the reference model.
      step();
      rst = 1'b1;
      wb(1'b0, 5'd0, 32'h0);
      step();
      rst = 1'b0;
      for (int r = 0; r < 32; r++) model_rf[r] = 32'h0;
      model_ill = 1'b0;
      for (int n = 0; n < 400; n++) begin
         logic [31:0] ins;
         logic [6:0]  opc;
         logic        lu;
         ctrl_t       ec;
         step();
         if ($urandom_range(0, 9) == 0) opc = 7'($urandom_range(0, 127));
         else opc = ops[$urandom_range(0, 8)];
         ins        = $urandom;
         ins[6:0]   = opc;
         ins[11:7]  = 5'($urandom_range(0, 7));
         ins[19:15] = 5'($urandom_range(0, 7));
         ins[24:20] = 5'($urandom_range(0, 7));
         drive(ins, $urandom, ($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0),
               $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)));
         wb($urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom);
         @(negedge clk);
         ec = ref_ctrl(ins, if_id_valid);
         lu = ref_load_use(ins);
         check("rnd_ctrl", 32'(dut_ctrl()), 32'(ec));
         check("rnd_pc", id_pc, if_id_pc);
         check("rnd_pc_p4", id_pc_p4, if_id_pc + 32'd4);
         check("rnd_fields", {id_funct7, id_funct3, id_rs1, id_rs2, id_rd, 7'd0},
               {ins[31:25], ins[14:12], ins[19:15], ins[24:20], ins[11:7], 7'd0});
         check("rnd_rd1", id_rd1, (opc == 7'h37) ? 32'h0 : ref_read(ins[19:15]));
         check("rnd_rd2", id_rd2, ref_read(ins[24:20]));
         if (ref_known(opc) && opc != 7'h33) check("rnd_imm", id_imm, ref_imm(ins));
         if (opc == 7'h63 || opc == 7'h6F)
            check("rnd_target", id_branch_target, if_id_pc + ref_imm(ins));
         check("rnd_pc_stall", 32'(pc_stall), 32'(lu && !ex_redirect));
         check("rnd_if_id_stall", 32'(if_id_stall), 32'(lu && !ex_redirect));
         check("rnd_flush", 32'(id_ex_flush), 32'(lu || ex_redirect || !if_id_valid));
         check("rnd_illegal", 32'(illegal_instr), 32'(model_ill));
         if (wb_reg_write && wb_rd != 5'd0) model_rf[wb_rd] = wb_data;
         if (if_id_valid && !ref_known(opc) && !ex_redirect) model_ill = 1'b1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
